// File: rtl/sr_latch_if.sv
// sr_latch_if: bundle between the requesters and the SR latch sequencer.
// Optional macro SR_CTRL_CONFLICT_CNT_EN adds the 8-bit conflict_cnt signal.
interface sr_latch_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0] set_req;
   logic [NREQ-1:0] clr_req;
   logic [NREQ-1:0] grant;
   logic            s;
   logic            r;
   logic            busy;
   logic            done;
   logic            conflict;
   logic            q_mirror;
`ifdef SR_CTRL_CONFLICT_CNT_EN
   logic [7:0]      conflict_cnt;

   modport master (
      output set_req, clr_req,
      input  grant, s, r, busy, done, conflict, q_mirror, conflict_cnt
   );
   modport slave (
      input  set_req, clr_req,
      output grant, s, r, busy, done, conflict, q_mirror, conflict_cnt
   );
`else
   modport master (
      output set_req, clr_req,
      input  grant, s, r, busy, done, conflict, q_mirror
   );
   modport slave (
      input  set_req, clr_req,
      output grant, s, r, busy, done, conflict, q_mirror
   );
`endif
endinterface

// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: shares one SR latch between NREQ requesters. Grants one
// set/clear operation at a time round-robin, drives s or r as a timed pulse
// followed by a recovery gap, and mirrors the latch state in q_mirror.
// After every reset the latch is forced to 0 with an r pulse.
// Optional macro SR_CTRL_CONFLICT_CNT_EN adds a saturating conflict counter.
module sr_latch_ctrl #(
   parameter int NREQ      = 4,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input logic       clk,
   input logic       rst,
   sr_latch_if.slave bus
);
   localparam int CMAX = (PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC;
   localparam int CW   = $clog2(CMAX) + 1;
   localparam int PW   = $clog2(NREQ);

   localparam logic [CW-1:0]   P_LAST   = CW'(PULSE_CYC);
   localparam logic [CW-1:0]   H_LAST   = CW'(HOLD_CYC);
   localparam logic [CW-1:0]   C_ONE    = CW'(1);
   localparam logic [NREQ-1:0] G_ONE    = NREQ'(1);
   localparam logic [PW-1:0]   PTR_LAST = PW'(NREQ - 1);

   typedef enum logic [2:0] {
      INIT_P,
      INIT_H,
      IDLE,
      PULSE,
      HOLD
   } state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [PW-1:0]   rr_ptr, rr_n;
   logic [PW-1:0]   scan_idx, pick_idx;
   logic            pick_found;
   logic [NREQ-1:0] elig;
   logic [NREQ-1:0] grant_n;
   logic            s_n, r_n, busy_n, done_n, q_n, conflict_n;

   // A requester asking for both set and clear is ambiguous and never eligible.
   assign elig       = bus.set_req ^ bus.clr_req;
   assign conflict_n = |(bus.set_req & bus.clr_req);

   // Round-robin search: first eligible requester at or after rr_ptr, wrapping.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no latch is inferred.
      pick_found = 1'b0;
      pick_idx   = '0;
      scan_idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         scan_idx = PW'((int'(rr_ptr) + i) % NREQ);
         if (!pick_found && elig[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      rr_n    = rr_ptr;
      s_n     = bus.s;
      r_n     = bus.r;
      q_n     = bus.q_mirror;
      grant_n = '0;
      done_n  = 1'b0;
      unique case (state)
         INIT_P: begin
            if (cnt == P_LAST) begin
               r_n     = 1'b0;
               cnt_n   = C_ONE;
               state_n = INIT_H;
            end else begin
               r_n   = 1'b1;
               cnt_n = cnt + C_ONE;
            end
         end
         INIT_H: begin
            if (cnt == H_LAST) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + C_ONE;
            end
         end
         IDLE: begin
            if (pick_found) begin
               state_n = PULSE;
               cnt_n   = C_ONE;
               grant_n = G_ONE << pick_idx;
               s_n     = bus.set_req[pick_idx];
               r_n     = bus.clr_req[pick_idx];
               rr_n    = (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;
            end
         end
         PULSE: begin
            if (cnt == P_LAST) begin
               // The pulse has completed, so the latch now holds the driven value.
               q_n     = bus.s;
               s_n     = 1'b0;
               r_n     = 1'b0;
               cnt_n   = C_ONE;
               done_n  = (H_LAST == C_ONE);
               state_n = HOLD;
            end else begin
               cnt_n = cnt + C_ONE;
            end
         end
         HOLD: begin
            if (cnt == H_LAST) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else begin
               cnt_n  = cnt + C_ONE;
               done_n = ((cnt + C_ONE) == H_LAST);
            end
         end
         default: begin
            state_n = INIT_P;
            cnt_n   = '0;
            s_n     = 1'b0;
            r_n     = 1'b0;
         end
      endcase
      busy_n = (state_n != IDLE);
   end

   // State, pointer, counter and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         state        <= INIT_P;
         cnt          <= '0;
         rr_ptr       <= '0;
         bus.s        <= 1'b0;
         bus.r        <= 1'b0;
         bus.grant    <= '0;
         bus.done     <= 1'b0;
         bus.busy     <= 1'b1;
         bus.conflict <= 1'b0;
         bus.q_mirror <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         rr_ptr       <= rr_n;
         bus.s        <= s_n;
         bus.r        <= r_n;
         bus.grant    <= grant_n;
         bus.done     <= done_n;
         bus.busy     <= busy_n;
         bus.conflict <= conflict_n;
         bus.q_mirror <= q_n;
      end
   end

`ifdef SR_CTRL_CONFLICT_CNT_EN
   // Saturating count of cycles in which conflict is registered high.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.conflict_cnt <= 8'h00;
      end else if (conflict_n && (bus.conflict_cnt != 8'hFF)) begin
         bus.conflict_cnt <= bus.conflict_cnt + 8'h01;
      end
   end
`endif

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// tb_sr_latch_ctrl: directed and random stimulus for sr_latch_ctrl. A
// schedule-based model predicts every output each cycle; directed sections
// also pin hand-computed values.
module tb_sr_latch_ctrl;
   localparam int NREQ      = 4;
   localparam int PULSE_CYC = 2;
   localparam int HOLD_CYC  = 1;

   logic clk;
   logic rst;

   sr_latch_if #(.NREQ(NREQ)) ifc ();

   sr_latch_ctrl #(
      .NREQ     (NREQ),
      .PULSE_CYC(PULSE_CYC),
      .HOLD_CYC (HOLD_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc)
   );

   int n_checks = 0;
   int n_err    = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- model: one expected output vector per clock edge ----------------
   typedef struct packed {
      logic s;
      logic r;
      logic busy;
      logic done;
      logic q;
   } step_t;

   step_t           sched[$];
   step_t           st;
   logic            m_valid = 1'b0;
   logic            m_q;
   int              m_rr;
   int              hit;
   logic [2*NREQ-1:0] rot;
   logic [NREQ-1:0] sh;
   logic            e_s, e_r, e_busy, e_done, e_q, e_conf;
   logic [NREQ-1:0] e_grant;
   logic [7:0]      e_cnt;

   always @(posedge clk) begin
      if (rst) begin
         sched.delete();
         m_q = 1'b0; m_rr = 0; m_valid = 1'b1;
         e_s = 1'b0; e_r = 1'b0; e_grant = '0; e_done = 1'b0; e_busy = 1'b1;
         e_q = 1'b0; e_conf = 1'b0; e_cnt = 8'h00;
         for (int i = 0; i < PULSE_CYC; i++) sched.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
         for (int i = 0; i < HOLD_CYC; i++)  sched.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
         sched.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      end else if (m_valid) begin
         e_conf = |(ifc.set_req & ifc.clr_req);
         if (e_conf && e_cnt != 8'hFF) e_cnt = e_cnt + 8'h01;
         e_grant = '0;
         if (sched.size() != 0) begin
            st = sched.pop_front();
            e_s = st.s; e_r = st.r; e_busy = st.busy; e_done = st.done; e_q = st.q;
         end else begin
            hit = -1;
            rot = {(ifc.set_req ^ ifc.clr_req), (ifc.set_req ^ ifc.clr_req)} >> m_rr;
            for (int i = 0; i < NREQ; i++) begin
               if (hit < 0 && rot[0]) hit = (m_rr + i) % NREQ;
               rot = rot >> 1;
            end
            if (hit >= 0) begin
               e_grant = NREQ'(1) << hit;
               sh = ifc.set_req >> hit; e_s = sh[0];
               sh = ifc.clr_req >> hit; e_r = sh[0];
               e_busy = 1'b1; e_done = 1'b0; e_q = m_q;
               for (int i = 1; i < PULSE_CYC; i++) sched.push_back('{e_s, e_r, 1'b1, 1'b0, m_q});
               m_q = e_s;
               for (int i = 0; i < HOLD_CYC; i++)
                  sched.push_back('{1'b0, 1'b0, 1'b1, (i == HOLD_CYC - 1), m_q});
               sched.push_back('{1'b0, 1'b0, 1'b0, 1'b0, m_q});
               m_rr = (hit + 1) % NREQ;
            end else begin
               e_s = 1'b0; e_r = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_q = m_q;
            end
         end
      end
   end

   // Compare DUT against the model on every falling edge once reset has been seen.
   always @(negedge clk) begin
      if (m_valid) begin
         check("s", ifc.s, e_s);
         check("r", ifc.r, e_r);
         check("grant", ifc.grant, e_grant);
         check("busy", ifc.busy, e_busy);
         check("done", ifc.done, e_done);
         check("q_mirror", ifc.q_mirror, e_q);
         check("conflict", ifc.conflict, e_conf);
         check("inv_s_and_r", ifc.s & ifc.r, 0);
         check("inv_onehot0_grant", $onehot0(ifc.grant), 1);
`ifdef SR_CTRL_CONFLICT_CNT_EN
         check("conflict_cnt", ifc.conflict_cnt, e_cnt);
`endif
      end
   end

   // ---------------- directed stimulus helpers ----------------
   task automatic wait_grant(input logic [NREQ-1:0] exp, input string nm, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ifc.grant == '0 && n < 20);
      check(nm, ifc.grant, exp);
      ifc.set_req = ifc.set_req & ~ifc.grant;
      ifc.clr_req = ifc.clr_req & ~ifc.grant;
   endtask

   task automatic do_reset();
      int n;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ifc.busy !== 1'b0 && n < 12);
      check("reset_init_done", ifc.busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [NREQ-1:0] g_exp;
      rst = 1'b1;
      ifc.set_req = '0;
      ifc.clr_req = '0;

      // 1: two reset edges, then INIT forces the latch low.
      repeat (2) @(negedge clk);
      check("t1_reset_r", ifc.r, 0);
      check("t1_reset_busy", ifc.busy, 1);
      rst = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         check("t1_r", ifc.r, (c <= 2));
         check("t1_s", ifc.s, 0);
         check("t1_busy", ifc.busy, (c < 4));
         check("t1_done", ifc.done, 0);
         check("t1_q", ifc.q_mirror, 0);
      end

      // 2: set by requester 2, then clear by requester 0.
      ifc.set_req = 4'b0100;
      wait_grant(4'b0100, "t2_grant_set", n);
      check("t2_s_first", ifc.s, 1);
      @(negedge clk);
      check("t2_s_second", ifc.s, 1);
      check("t2_grant_pulse", ifc.grant, 0);
      @(negedge clk);
      check("t2_s_off", ifc.s, 0);
      check("t2_done", ifc.done, 1);
      check("t2_q_set", ifc.q_mirror, 1);
      @(negedge clk);
      check("t2_done_off", ifc.done, 0);
      check("t2_idle", ifc.busy, 0);
      ifc.clr_req = 4'b0001;
      wait_grant(4'b0001, "t2_grant_clr", n);
      check("t2_r_first", ifc.r, 1);
      @(negedge clk);
      check("t2_r_second", ifc.r, 1);
      @(negedge clk);
      check("t2_r_off", ifc.r, 0);
      check("t2_q_clr", ifc.q_mirror, 0);
      check("t2_done_clr", ifc.done, 1);

      // 3: all four request set from rr_ptr=0; grants in order, 4 cycles apart.
      do_reset();
      ifc.set_req = 4'b1111;
      for (int k = 0; k < NREQ; k++) begin
         g_exp = NREQ'(1) << k;
         wait_grant(g_exp, "t3_grant_order", n);
         if (k > 0) check("t3_grant_gap", n, 4);
         check("t3_s", ifc.s, 1);
      end

      // 4: requester 1 in conflict, requester 3 clears; only requester 3 is served.
      @(negedge clk);
      while (ifc.busy !== 1'b0) @(negedge clk);
      ifc.set_req = 4'b0010;
      ifc.clr_req = 4'b1010;
      wait_grant(4'b1000, "t4_grant3", n);
      check("t4_r", ifc.r, 1);
      check("t4_conflict", ifc.conflict, 1);
      for (int c = n; c < 12; c++) begin
         @(negedge clk);
         check("t4_no_grant1", ifc.grant[1], 0);
      end
      ifc.set_req = '0;
      ifc.clr_req = '0;
      @(negedge clk);
      check("t4_conflict_off", ifc.conflict, 0);
`ifdef SR_CTRL_CONFLICT_CNT_EN
      check("t4_conflict_cnt", ifc.conflict_cnt, 12);
`endif

      // 5: set q, then reset during the 2nd pulse cycle of another set.
      ifc.set_req = 4'b0001;
      wait_grant(4'b0001, "t5_grant0", n);
      repeat (3) @(negedge clk);
      check("t5_q_before", ifc.q_mirror, 1);
      ifc.set_req = 4'b0100;
      wait_grant(4'b0100, "t5_grant2", n);
      @(negedge clk);
      check("t5_s_pulse2", ifc.s, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_s_dropped", ifc.s, 0);
      check("t5_r_reset", ifc.r, 0);
      check("t5_done_none", ifc.done, 0);
      check("t5_q_zero", ifc.q_mirror, 0);
      check("t5_busy", ifc.busy, 1);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check("t5_init_r", ifc.r, (c <= 2));
         check("t5_init_done", ifc.done, 0);
      end

      // 6: random protocol-compliant requests with occasional resets.
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 599) == 0);
         for (int i = 0; i < NREQ; i++) begin
            if (ifc.grant[i]) begin
               ifc.set_req[i] = 1'b0;
               ifc.clr_req[i] = 1'b0;
            end else if (!ifc.set_req[i] && !ifc.clr_req[i]) begin
               if ($urandom_range(0, 5) == 0) begin
                  n = $urandom_range(0, 9);
                  ifc.set_req[i] = (n < 5) || (n == 9);
                  ifc.clr_req[i] = (n >= 5);
               end
            end else if (ifc.set_req[i] && ifc.clr_req[i] && $urandom_range(0, 3) == 0) begin
               ifc.set_req[i] = 1'b0;
               ifc.clr_req[i] = 1'b0;
            end
         end
      end
      rst = 1'b0;
      ifc.set_req = '0;
      ifc.clr_req = '0;
      repeat (10) @(negedge clk);
      check("end_idle", ifc.busy, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule
